// File: rtl/clk_div_bank.sv
// Bank of N_CH independent clock dividers with per-channel tick pulses and a stretched reset_out.
// Define CLKDIV_PHASE_RESET_EN to make divisor loads restart the channel phase at once, instead of taking effect at the next terminal count.
module clk_div_bank #(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 23,
    parameter int unsigned DEF_DIV   = 2**(CNT_W-1),
    parameter int          RST_TICKS = 3,
    localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             div_valid,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_ready,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic             reset_out
);

    localparam int RT_W = $clog2(RST_TICKS + 2);

    logic [CNT_W-1:0] div_q [N_CH];
    logic [CNT_W-1:0] cnt   [N_CH];
    logic [N_CH-1:0]  term;
    logic [N_CH-1:0]  load_sel;
    logic [RT_W-1:0]  rcnt;

`ifdef CLKDIV_PHASE_RESET_EN
    assign div_ready = 1'b1;
`else
    logic [CNT_W-1:0] shadow [N_CH];
    logic [N_CH-1:0]  pending;

    // An out-of-range div_ch matches no channel, so the handshake still completes.
    always_comb begin
        div_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if ((div_ch == CH_W'(i)) && pending[i]) div_ready = 1'b0;
        end
    end
`endif

    // A divisor of 0 is treated as 1, so the terminal count is then 0.
    always_comb begin
        term     = '0;
        load_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            term[i]     = (cnt[i] == ((div_q[i] == '0) ? '0 : div_q[i] - CNT_W'(1)));
            load_sel[i] = div_valid && div_ready && (div_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= CNT_W'(DEF_DIV);
                cnt[i]   <= '0;
`ifndef CLKDIV_PHASE_RESET_EN
                shadow[i] <= CNT_W'(DEF_DIV);
`endif
            end
            clk_out <= '0;
            tick    <= '0;
`ifndef CLKDIV_PHASE_RESET_EN
            pending <= '0;
`endif
        end else begin
            for (int i = 0; i < N_CH; i++) begin
`ifdef CLKDIV_PHASE_RESET_EN
                if (load_sel[i]) begin
                    div_q[i]   <= div_value;
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else begin
                    tick[i] <= term[i];
                    if (term[i]) begin
                        cnt[i]     <= '0;
                        clk_out[i] <= ~clk_out[i];
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
`else
                tick[i] <= term[i];
                if (term[i]) begin
                    // The terminal count itself still runs on the old divisor.
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    pending[i] <= 1'b0;
                    if (load_sel[i])     div_q[i] <= div_value;
                    else if (pending[i]) div_q[i] <= shadow[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                    if (load_sel[i]) begin
                        shadow[i]  <= div_value;
                        pending[i] <= 1'b1;
                    end
                end
`endif
            end
        end
    end

    // reset_out counts registered channel-0 ticks, so it drops one cycle after the last one.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            reset_out <= 1'b1;
            rcnt      <= '0;
        end else if (reset_out) begin
            if (RST_TICKS == 0) begin
                reset_out <= 1'b0;
            end else if (tick[0]) begin
                rcnt <= rcnt + RT_W'(1);
                if (int'(rcnt) == RST_TICKS - 1) reset_out <= 1'b0;
            end
        end
    end

endmodule
